dct_2d_sequencer: RTL and testbench

Control and accumulate engine for the 8x8 2-D DCT. It walks all 64 output coefficients (k1,k2). For each one it sweeps all 64 input pixels (n1,n2), driving the external cosine-LUT bank and the pixel buffer, and multiply-accumulates pixel × cos_term. It then normalises the sum and hands each coefficient downstream over a valid/ready port. It sits between the frame tile buffer and the quantiser.

---
 rtl/dct_2d_sequencer.sv | 158 +++++++++++++++
 tb/tb_dct_2d_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dct_2d_sequencer.sv
// 8x8 2-D DCT control and multiply-accumulate engine with a valid/ready coefficient output.
// Define DCT_SEQ_LEVEL_SHIFT_EN to subtract 128 from each pixel before the multiply.
module dct_2d_sequencer #(
    parameter int unsigned OUT_SHIFT = 10,
    parameter int unsigned ACC_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [5:0]         pix_addr,
    input  logic [7:0]         pix_data,
    output logic [2:0]         lut_k1,
    output logic [2:0]         lut_k2,
    output logic [2:0]         lut_n1,
    output logic [2:0]         lut_n2,
    input  logic signed [31:0] lut_cos,
    output logic               coef_valid,
    input  logic               coef_ready,
    output logic [5:0]         coef_addr,
    output logic signed [31:0] coef_data
);

    typedef enum logic [2:0] {
        StIdle,
        StMac,
        StDrain,
        StWrite,
        StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [5:0]               k_q, k_d;
    logic [5:0]               n_q, n_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [31:0]       cos_q, cos_d;
    logic                     term_valid_q, term_valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     coef_valid_q, coef_valid_d;

    logic signed [8:0]        p;
    logic signed [40:0]       prod;

    always_comb begin
`ifdef DCT_SEQ_LEVEL_SHIFT_EN
        p = $signed({1'b0, pix_data}) - 9'sd128;
`else
        p = $signed({1'b0, pix_data});
`endif
        prod = p * cos_q;
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        n_d          = n_q;
        acc_d        = acc_q;
        cos_d        = cos_q;
        term_valid_d = 1'b0;

        // The term issued last cycle has its pixel on pix_data now.
        if (term_valid_q) begin
            acc_d = acc_q + ACC_W'(prod);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StMac;
                    k_d     = '0;
                    n_d     = '0;
                    acc_d   = '0;
                end
            end
            StMac: begin
                cos_d        = lut_cos;
                term_valid_d = 1'b1;
                if (n_q == 6'd63) begin
                    state_d = StDrain;
                end else begin
                    n_d = n_q + 6'd1;
                end
            end
            StDrain: begin
                state_d = StWrite;
            end
            StWrite: begin
                if (coef_ready) begin
                    if (k_q == 6'd63) begin
                        state_d = StDone;
                    end else begin
                        state_d = StMac;
                        k_d     = k_q + 6'd1;
                        n_d     = '0;
                        acc_d   = '0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d       = (state_d != StIdle);
        done_d       = (state_d == StDone);
        coef_valid_d = (state_d == StWrite);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            k_q          <= '0;
            n_q          <= '0;
            acc_q        <= '0;
            cos_q        <= '0;
            term_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            coef_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            n_q          <= n_d;
            acc_q        <= acc_d;
            cos_q        <= cos_d;
            term_valid_q <= term_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            coef_valid_q <= coef_valid_d;
        end
    end

    // DC rows/columns carry an extra 1/sqrt(2) (181/256) per axis.
    logic signed [47:0] s0, s1, s2;

    always_comb begin
        s0 = 48'(acc_q);
        s1 = (k_q[5:3] == 3'd0) ? ((s0 * 48'sd181) >>> 8) : s0;
        s2 = (k_q[2:0] == 3'd0) ? ((s1 * 48'sd181) >>> 8) : s1;
        coef_data = 32'(s2 >>> OUT_SHIFT);
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign coef_valid = coef_valid_q;
    assign coef_addr  = k_q;
    assign pix_addr   = n_q;
    assign lut_k1     = k_q[5:3];
    assign lut_k2     = k_q[2:0];
    assign lut_n1     = n_q[5:3];
    assign lut_n2     = n_q[2:0];

endmodule

// File: tb/tb_dct_2d_sequencer.sv
// Scoreboard bench for dct_2d_sequencer: directed pixel blocks with hand-computed coefficients.
module tb_dct_2d_sequencer;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               busy;
    logic               done;
    logic [5:0]         pix_addr;
    logic [7:0]         pix_data;
    logic [2:0]         lut_k1, lut_k2, lut_n1, lut_n2;
    logic signed [31:0] lut_cos;
    logic               coef_valid;
    logic               coef_ready;
    logic [5:0]         coef_addr;
    logic signed [31:0] coef_data;

    always #5 clk = ~clk;

    dct_2d_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pix_addr  (pix_addr),
        .pix_data  (pix_data),
        .lut_k1    (lut_k1),
        .lut_k2    (lut_k2),
        .lut_n1    (lut_n1),
        .lut_n2    (lut_n2),
        .lut_cos   (lut_cos),
        .coef_valid(coef_valid),
        .coef_ready(coef_ready),
        .coef_addr (coef_addr),
        .coef_data (coef_data)
    );

`ifdef DCT_SEQ_LEVEL_SHIFT_EN
    localparam bit LvlShift = 1'b1;
`else
    localparam bit LvlShift = 1'b0;
`endif

    int         lut_tab [4096];
    logic [7:0] pix_mem [64];

    always @(posedge clk) pix_data <= pix_mem[pix_addr];
    always_comb lut_cos = lut_tab[{lut_k1, lut_k2, lut_n1, lut_n2}];

    typedef struct {
        logic [5:0]         addr;
        logic signed [31:0] data;
        bit                 chk;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input longint got, input longint req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    task automatic fill_lut();
        real pi, c [8][8];
        pi = 3.14159265358979323846;
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++)
                c[k][n] = $cos(real'((2 * n + 1) * k) * pi / 16.0);
        for (int k1 = 0; k1 < 8; k1++)
            for (int k2 = 0; k2 < 8; k2++)
                for (int n1 = 0; n1 < 8; n1++)
                    for (int n2 = 0; n2 < 8; n2++)
                        lut_tab[k1 * 512 + k2 * 64 + n1 * 8 + n2] =
                            rnd(256.0 * c[k1][n1] * c[k2][n2]);
    endtask

    task automatic push(input int addr, input int data, input bit chk);
        exp_t e;
        e.addr = 6'(addr);
        e.data = data;
        e.chk  = chk;
        sb_q.push_back(e);
    endtask

    // Pops one expectation per accepted coefficient.
    task automatic run_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && coef_valid && coef_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_coef_addr", coef_addr, -1);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("coef_addr[%0d]", e.addr), coef_addr, e.addr);
                    if (e.chk) check($sformatf("coef_data[%0d]", e.addr), coef_data, e.data);
                end
            end
        end
    endtask

    task automatic run_block(input bit hold_start, input int stall_k, input int exp_cycles);
        int   cyc, busy_cnt, done_cnt, done_cyc, stalled;
        bit   stable_ok;
        logic signed [31:0] snap_data;
        logic [5:0]         snap_pix;
        busy_cnt = 0; done_cnt = 0; done_cyc = 0; stalled = 0; stable_ok = 1'b1;
        snap_data = '0; snap_pix = '0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        cyc = 1;
        while (cyc <= exp_cycles + 50 && done_cyc == 0) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (stall_k >= 0 && coef_valid && coef_addr == 6'(stall_k) && stalled < 6) begin
                if (stalled == 0) begin
                    snap_data = coef_data;
                    snap_pix  = pix_addr;
                end else if (coef_data !== snap_data || pix_addr !== snap_pix) begin
                    stable_ok = 1'b0;
                end
                coef_ready = (stalled == 5);
                stalled++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("done_cycle", done_cyc, exp_cycles);
        check("busy_cycles", busy_cnt, exp_cycles);
        if (stall_k >= 0) begin
            check("stall_cycles", stalled, 6);
            check("stall_stable", stable_ok, 1);
        end
        check("done_pulse_low", done, 0);
        check("idle_after_done", busy, 0);
        check("scoreboard_drained", sb_q.size(), 0);
        if (hold_start) begin
            @(posedge clk); #1;
            check("restart_from_idle", busy, 1);
            start = 1'b0;
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        coef_ready = 1'b1;
        fill_lut();
        for (int i = 0; i < 64; i++) pix_mem[i] = 8'd128;
        fork
            run_monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_coef_valid", coef_valid, 0);
        check("rst_pix_addr", pix_addr, 0);
        check("rst_lut", {lut_k1, lut_k2, lut_n1, lut_n2}, 0);
        check("rst_coef_addr", coef_addr, 0);
        check("rst_coef_data", coef_data, 0);
        rst_n = 1'b1;

        // Abort a block at cycle 100 while coefficient 0 sits unaccepted.
        coef_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (99) begin
            @(posedge clk); #1;
        end
        check("mid_busy", busy, 1);
        check("mid_coef_valid", coef_valid, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_coef_valid", coef_valid, 0);
        check("abort_done", done, 0);
        rst_n      = 1'b1;
        coef_ready = 1'b1;

        // Flat 128 block with backpressure on coefficient 7.
        for (int k = 0; k < 64; k++) push(k, (k == 0 && !LvlShift) ? 1023 : 0, 1'b1);
        run_block(1'b0, 7, 4230);

        // Flat 255 block, start held high throughout.
        for (int i = 0; i < 64; i++) pix_mem[i] = 8'd255;
        for (int k = 0; k < 64; k++) push(k, (k == 0) ? (LvlShift ? 1015 : 2039) : 0, 1'b1);
        run_block(1'b1, -1, 4225);

        // Impulse at pixel (0,0).
        for (int i = 0; i < 64; i++) pix_mem[i] = 8'd128;
        pix_mem[0] = 8'd255;
        for (int k = 0; k < 64; k++) begin
            case (k)
                0:       push(k, LvlShift ? 15 : 1039, 1'b1);
                1, 8:    push(k, 22, 1'b1);
                9:       push(k, 30, 1'b1);
                default: push(k, 0, 1'b0);
            endcase
        end
        run_block(1'b0, -1, 4225);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
